// File: rtl/adc_spi_scanner_pkg.sv
// ============================================================================
// Module   : adc_pkg
// Purpose  : Shared types and helpers for the multi-channel SPI ADC scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_NULL = 3'd2,
        S_DATA = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    // First bit of every command header
    localparam logic c_CMD_START_BIT = 1'b1;

    // Channel-number width; a single-channel build still carries one bit
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    // Command header length: start bit, mode bit, channel number
    function automatic int cmd_len(input int ch_w);
        return 2 + ch_w;
    endfunction

    // Serial-clock periods per conversion frame: CMD + NULL + DATA + GAP
    function automatic int frame_len(input int data_bits, input int ch_w);
        return cmd_len(ch_w) + 1 + data_bits + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_spi_scanner_if.sv
// ============================================================================
// Module   : adc_spi_scanner_if
// Purpose  : Control/result handshake plus ADC serial pins of the scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_spi_scanner_if
    import adc_pkg::*;
#(
    parameter int DATA_BITS = 12,
    parameter int NUM_CH    = 2,
    parameter int CH_W      = ch_width(NUM_CH)
);
    logic                  start;
    logic                  continuous;
    logic                  diff_mode;
    logic [NUM_CH-1:0]     ch_mask;
    logic                  miso;
    logic                  cs_n;
    logic                  sclk;
    logic                  mosi;
    logic [DATA_BITS-1:0]  sample;
    logic [CH_W-1:0]       sample_ch;
    logic                  sample_valid;
    logic                  busy;
    logic                  done;

    // Collector + ADC side
    modport master (
        output start, continuous, diff_mode, ch_mask, miso,
        input  cs_n, sclk, mosi, sample, sample_ch, sample_valid, busy, done
    );

    // Scanner side
    modport slave (
        input  start, continuous, diff_mode, ch_mask, miso,
        output cs_n, sclk, mosi, sample, sample_ch, sample_valid, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/adc_spi_scanner_sclk.sv
// ============================================================================
// Module   : adc_sclk_gen
// Purpose  : Bit-period divider producing sclk, end-of-period tick and the
//            miso sample strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sclk_gen #(
    parameter int CLK_DIV = 28
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_en,       // low holds the count at 0
    input  wire logic i_sclk_en,  // low forces sclk low for the whole period
    output logic      o_sclk,
    output logic      o_tick,     // last cycle of a period; registered state lands on div==0
    output logic      o_sample    // div == CLK_DIV/4, miso is sampled at the end of this cycle
);
    localparam int c_DIV_W = $clog2(CLK_DIV);
    localparam int c_HALF  = CLK_DIV / 2;
    localparam int c_QTR   = CLK_DIV / 4;

    logic [c_DIV_W-1:0] r_div;
    logic [c_DIV_W-1:0] w_div_nxt;
    logic               r_sclk;

    // Next divider value: wrap at CLK_DIV-1, park at 0 while disabled
    always_comb begin
        w_div_nxt = '0;
        if (i_en && (r_div != c_DIV_W'(CLK_DIV - 1)))
            w_div_nxt = r_div + 1'b1;
    end

    // Divider and sclk registers; sclk is derived from the next count so it is aligned with div
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else begin
            r_div  <= w_div_nxt;
            r_sclk <= i_en && i_sclk_en && (w_div_nxt >= c_DIV_W'(c_HALF));
        end
    end

    assign o_sclk   = r_sclk;
    assign o_tick   = i_en && (r_div == c_DIV_W'(CLK_DIV - 1));
    assign o_sample = i_en && (r_div == c_DIV_W'(c_QTR));
endmodule

`default_nettype wire

// File: rtl/adc_spi_scanner.sv
// ============================================================================
// Module   : adc_spi_scanner
// Purpose  : Scans enabled ADC channels over SPI, one tagged sample per frame,
//            with start/busy/done handshake and optional continuous passes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_spi_scanner
    import adc_pkg::*;
#(
    parameter int CLK_DIV   = 28,
    parameter int DATA_BITS = 12,
    parameter int NUM_CH    = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    adc_spi_scanner_if.slave  bus
);
    localparam int c_CH_W    = ch_width(NUM_CH);
    localparam int c_CMD_LEN = cmd_len(c_CH_W);
    localparam int c_CNT_W   = $clog2(DATA_BITS + c_CMD_LEN);

    state_t                r_state, w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [c_CH_W-1:0]     r_ch, w_ch_nxt;
    logic [NUM_CH-1:0]     r_mask, w_mask_nxt;
    logic                  r_diff, w_diff_nxt;
    logic                  w_pass_end;
    logic [c_CH_W:0]       w_hit;
    logic [DATA_BITS-1:0]  r_sr;

    logic                  w_tick, w_sample, w_sclk;
    logic                  w_cs_n_nxt, w_mosi_nxt, w_valid_nxt, w_busy_nxt;
    logic [c_CMD_LEN-1:0]  w_cmd, w_cmd_sh;

    logic                  r_cs_n, r_mosi, r_valid, r_busy, r_done;
    logic [DATA_BITS-1:0]  r_sample;
    logic [c_CH_W-1:0]     r_sample_ch;

    // Lowest enabled channel at or above 'from'; MSB of the result flags a hit
    function automatic logic [c_CH_W:0] find_en(input logic [NUM_CH-1:0] mask, input int from);
        logic [c_CH_W:0] res;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (mask[i] && (i >= from))
                res = {1'b1, c_CH_W'(i)};
        return res;
    endfunction

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (r_state != S_IDLE),
        .i_sclk_en (r_state != S_GAP),
        .o_sclk    (w_sclk),
        .o_tick    (w_tick),
        .o_sample  (w_sample)
    );

    // State and per-pass context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_mask  <= '0;
            r_diff  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ch    <= w_ch_nxt;
            r_mask  <= w_mask_nxt;
            r_diff  <= w_diff_nxt;
        end
    end

    // Next-state: frames advance on period boundaries, channel walk happens at GAP exit
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ch_nxt    = r_ch;
        w_mask_nxt  = r_mask;
        w_diff_nxt  = r_diff;
        w_pass_end  = 1'b0;
        w_hit       = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (|bus.ch_mask) begin
                        w_hit       = find_en(bus.ch_mask, 0);
                        w_state_nxt = S_CMD;
                        w_cnt_nxt   = '0;
                        w_ch_nxt    = w_hit[c_CH_W-1:0];
                        w_mask_nxt  = bus.ch_mask;
                        w_diff_nxt  = bus.diff_mode;
                    end else begin
                        w_pass_end  = 1'b1;
                    end
                end
            end
            S_CMD: begin
                if (w_tick) begin
                    if (r_cnt == c_CNT_W'(c_CMD_LEN - 1)) begin
                        w_state_nxt = S_NULL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            S_NULL: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_cnt == c_CNT_W'(DATA_BITS - 1)) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    w_cnt_nxt = '0;
                    w_hit     = find_en(r_mask, int'(r_ch) + 1);
                    if (w_hit[c_CH_W]) begin
                        w_state_nxt = S_CMD;
                        w_ch_nxt    = w_hit[c_CH_W-1:0];
                    end else begin
                        w_pass_end = 1'b1;
                        if (bus.continuous && (|bus.ch_mask)) begin
                            w_hit       = find_en(bus.ch_mask, 0);
                            w_state_nxt = S_CMD;
                            w_ch_nxt    = w_hit[c_CH_W-1:0];
                            w_mask_nxt  = bus.ch_mask;
                            w_diff_nxt  = bus.diff_mode;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every pin is a register
    always_comb begin
        w_cmd       = {c_CMD_START_BIT, ~w_diff_nxt, w_ch_nxt};
        w_cmd_sh    = w_cmd << w_cnt_nxt;
        w_cs_n_nxt  = !((w_state_nxt == S_CMD) || (w_state_nxt == S_NULL) || (w_state_nxt == S_DATA));
        w_mosi_nxt  = (w_state_nxt == S_CMD) && w_cmd_sh[c_CMD_LEN-1];
        w_valid_nxt = w_tick && (r_state == S_DATA) && (w_state_nxt == S_GAP);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
    end

    // Registered pins and result latch at GAP entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sample    <= '0;
            r_sample_ch <= '0;
        end else begin
            r_cs_n  <= w_cs_n_nxt;
            r_mosi  <= w_mosi_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_pass_end;
            if (w_valid_nxt) begin
                r_sample    <= r_sr;
                r_sample_ch <= r_ch;
            end
        end
    end

    // Result shift register, MSB arrives first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sr <= '0;
        else if ((r_state == S_DATA) && w_sample)
            r_sr <= {r_sr[DATA_BITS-2:0], bus.miso};
    end

    assign bus.cs_n         = r_cs_n;
    assign bus.sclk         = w_sclk;
    assign bus.mosi         = r_mosi;
    assign bus.sample       = r_sample;
    assign bus.sample_ch    = r_sample_ch;
    assign bus.sample_valid = r_valid;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
endmodule

`default_nettype wire
